l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- Shares the single request port of the level-2 cache between the instruction-side L1 (read-only) and the data-side L1 (read/write).
- Latches the winning request, drives the L2 read/write strobes, address and write data from registers, and holds them while the L2 stalls for a line fill.
- Returns the 128-bit half-line to the winner with a one-cycle ack.
- Sits between the two L1 controllers and the L2 cache.

Parameters:
- TIMEOUT, 64: maximum ACCESS cycles with l2_stall high before the transaction is aborted.
- CNT_W, 7: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-side read request; held until i_ack.
- i_addr  in  32  I-side word address.
- d_req  in  1  D-side request; held until d_ack.
- d_we  in  1  D-side request type: 1 = write, 0 = read.
- d_addr  in  32  D-side word address.
- d_wdata  in  32  D-side write data.
- i_ack  out  1  one-cycle pulse; I-side transaction complete.
- d_ack  out  1  one-cycle pulse; D-side transaction complete.
- i_block  out  128  I-side read result; valid from i_ack onward.
- d_block  out  128  D-side read result; valid from d_ack onward.
- l2_read  out  1  read strobe to the L2.
- l2_write  out  1  write strobe to the L2.
- l2_addr  out  32  address to the L2.
- l2_wdata  out  32  write data to the L2.
- l2_stall  in  1  L2 miss stall; only meaningful while l2_read=1.
- l2_block  in  128  L2 half-line output; combinational from l2_addr.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky flag; set on timeout.

Behaviour:
- Reset (rst=0, asynchronous), all values:
  - state = IDLE.
  - i_ack, d_ack, l2_read, l2_write, busy, err = 0.
  - l2_addr, l2_wdata = 0.
  - i_block, d_block = 0.
  - last_grant = D, so the first tie goes to I.
  - Timeout counter = 0.
- Reset asserted mid-transaction aborts it: no ack is issued, and strobes drop immediately (asynchronously).
- Registered outputs: every output except busy is a register. busy = (state != IDLE).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Neither req high: remain in IDLE.
  - Only one req high: grant that requester.
  - Both high: grant the requester that is not last_grant (round-robin).
  - On grant:
    - Latch the winner's address into l2_addr.
    - For D-side, latch d_wdata into l2_wdata.
    - Set l2_read = !we, l2_write = we. I-side always has we = 0.
    - Set last_grant to the winner, clear the counter, go to ACCESS.
- ACCESS, write:
  - Lasts exactly 1 cycle, since the L2 never stalls a write.
  - Next edge: l2_write <= 0, d_ack <= 1, go to RESP.
- ACCESS, read, l2_stall = 0:
  - Capture l2_block into the winner's block register.
  - l2_read <= 0, winner's ack <= 1, go to RESP.
- ACCESS, read, l2_stall = 1:
  - Hold l2_addr and l2_read unchanged; counter increments.
  - If the counter equals TIMEOUT-1 on this edge: err <= 1, l2_read <= 0, winner's ack <= 1, block register unchanged, go to RESP.
- RESP:
  - Lasts 1 cycle with the ack high; then ack <= 0 and go to IDLE.
  - The requester must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Latency from req high in IDLE to ack high:
  - Read hit or write: 2 edges.
  - Read miss: 2 + N edges, where N = stall cycles. The L2 fill gives N = 9.
- Losing requester: its req stays pending untouched and is granted at the first IDLE after the winner's RESP. Maximum wait is one transaction.
- Requests arriving during ACCESS/RESP are not sampled until IDLE.
- The l2_wdata register holds its last value during reads.
- err clears only on reset.
- Address is passed through unmodified (full 32 bits). Half-line selection is done by the L2 from address bit 2.

Test Plan:
1. Reset then i_req=1, i_addr=0x40, l2_stall=0, l2_block=0xA5..A5 -> l2_read=1 with l2_addr=0x40 on cycle 1; i_ack=1 on cycle 2 with i_block=0xA5..A5; busy low on cycle 3.
2. i_req and d_req (read) raised on the same cycle after reset -> I granted first, D granted at the following IDLE. Repeat the same-cycle raise -> D granted first (round-robin alternates).
3. d_req=1, d_we=1, d_addr=0x13, d_wdata=0xDEADBEEF -> l2_write=1 for exactly one cycle with l2_addr=0x13 and l2_wdata=0xDEADBEEF; d_ack two edges after the request.
4. D read with l2_stall high for 9 cycles, l2_block=0x1234 thereafter -> l2_addr stable through all stall cycles; d_ack 11 edges after request; d_block=0x1234. Meanwhile an i_req raised mid-stall is granted only after d_ack.
5. l2_stall held high, TIMEOUT=64 -> after 64 ACCESS cycles: err=1, l2_read=0, i_ack pulses, i_block unchanged. err stays 1 across later transactions until rst=0.
6. rst driven low during ACCESS of a read miss -> l2_read=0 immediately, no ack, busy=0. After release, the held i_req restarts from IDLE with a fresh grant.

Source files
------------

// File: rtl/l2_port_arbiter_if.sv
// Bundle of L1-side request/ack signals and L2-side strobes around the L2 port arbiter.
// The arbiter takes the slave view; the requesters/L2 model take the master view.
interface l2_port_arbiter_if;
    logic         i_req;
    logic [31:0]  i_addr;
    logic         d_req;
    logic         d_we;
    logic [31:0]  d_addr;
    logic [31:0]  d_wdata;
    logic         i_ack;
    logic         d_ack;
    logic [127:0] i_block;
    logic [127:0] d_block;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_addr;
    logic [31:0]  l2_wdata;
    logic         l2_stall;
    logic [127:0] l2_block;
    logic         busy;
    logic         err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, l2_stall, l2_block,
        output i_ack, d_ack, i_block, d_block, l2_read, l2_write, l2_addr, l2_wdata,
               busy, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, l2_stall, l2_block,
        input  i_ack, d_ack, i_block, d_block, l2_read, l2_write, l2_addr, l2_wdata,
               busy, err
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2 request port between the I-side and D-side L1s,
// with registered strobes, stall hold, timeout abort and a one-cycle ack per transaction.
module l2_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic            clk,
    input logic            rst,
    l2_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic               last_d_q, last_d_d;
    logic               win_d_q, win_d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [127:0]       i_block_q, i_block_d;
    logic [127:0]       d_block_q, d_block_d;
    logic               l2_read_q, l2_read_d;
    logic               l2_write_q, l2_write_d;
    logic [31:0]        l2_addr_q, l2_addr_d;
    logic [31:0]        l2_wdata_q, l2_wdata_d;
    logic               err_q, err_d;

    logic               grant_i, grant_d;
    logic               timeout_hit;

    // On a tie the side that did not win last time gets the port.
    assign grant_i     = bus.i_req && (!bus.d_req || last_d_q);
    assign grant_d     = bus.d_req && !grant_i;
    assign timeout_hit = bus.l2_stall && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_i || grant_d) state_d = ACCESS;
            ACCESS:  if (l2_write_q || !bus.l2_stall || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d_d   = last_d_q;
        win_d_d    = win_d_q;
        cnt_d      = cnt_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        i_block_d  = i_block_q;
        d_block_d  = d_block_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    l2_addr_d  = grant_d ? bus.d_addr : bus.i_addr;
                    if (grant_d) l2_wdata_d = bus.d_wdata;
                    l2_read_d  = grant_i || !bus.d_we;
                    l2_write_d = grant_d && bus.d_we;
                    last_d_d   = grant_d;
                    win_d_d    = grant_d;
                    cnt_d      = '0;
                end
            end
            ACCESS: begin
                if (l2_write_q) begin
                    l2_write_d = 1'b0;
                    d_ack_d    = 1'b1;
                end else if (!bus.l2_stall) begin
                    if (win_d_q) d_block_d = bus.l2_block;
                    else         i_block_d = bus.l2_block;
                    l2_read_d = 1'b0;
                    d_ack_d   = win_d_q;
                    i_ack_d   = !win_d_q;
                end else if (timeout_hit) begin
                    // Abort: ack the winner so it is not stuck, but leave its block untouched.
                    err_d     = 1'b1;
                    l2_read_d = 1'b0;
                    d_ack_d   = win_d_q;
                    i_ack_d   = !win_d_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q   <= 1'b1;
            win_d_q    <= 1'b0;
            cnt_q      <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_block_q  <= '0;
            d_block_q  <= '0;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            last_d_q   <= last_d_d;
            win_d_q    <= win_d_d;
            cnt_q      <= cnt_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            i_block_q  <= i_block_d;
            d_block_q  <= d_block_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.i_ack    = i_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.i_block  = i_block_q;
    assign bus.d_block  = d_block_q;
    assign bus.l2_read  = l2_read_q;
    assign bus.l2_write = l2_write_q;
    assign bus.l2_addr  = l2_addr_q;
    assign bus.l2_wdata = l2_wdata_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: expected acks are queued when a request is raised
// and popped when the arbiter acks, plus timing checks on strobes, latency and reset.
module tb_l2_port_arbiter;

    typedef struct {
        logic         is_d;
        logic [127:0] block;
    } exp_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    exp_t sb[$];
    logic [127:0] model_i_block;
    logic [127:0] model_d_block;

    l2_port_arbiter_if bus();

    l2_port_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_reset();
        rst          = 1'b0;
        bus.i_req    = 1'b0;
        bus.i_addr   = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.l2_stall = 1'b0;
        bus.l2_block = '0;
        sb.delete();
        model_i_block = '0;
        model_d_block = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_exp(input logic is_d, input logic [127:0] blk);
        exp_t e;
        e.is_d  = is_d;
        e.block = blk;
        sb.push_back(e);
        if (is_d) model_d_block = blk;
        else      model_i_block = blk;
    endtask

    function automatic exp_t sb_pop();
        exp_t e;
        e.is_d  = 1'bx;
        e.block = 'x;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    // Counts falling edges until either ack is seen or the limit expires.
    task automatic wait_ack(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.i_ack || bus.d_ack) && n < limit);
    endtask

    task automatic test_reset();
        apply_reset();
        compared++;
        if ({bus.i_ack, bus.d_ack, bus.l2_read, bus.l2_write, bus.busy, bus.err} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got ack_i/ack_d/rd/wr/busy/err=%b, expected 000000",
                     {bus.i_ack, bus.d_ack, bus.l2_read, bus.l2_write, bus.busy, bus.err});
        end
        compared++;
        if (bus.l2_addr !== 32'h0 || bus.l2_wdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_bus: got addr=%h wdata=%h, expected 0/0", bus.l2_addr, bus.l2_wdata);
        end
        compared++;
        if (bus.i_block !== 128'h0 || bus.d_block !== 128'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_blocks: got i=%h d=%h, expected 0/0", bus.i_block, bus.d_block);
        end
    endtask

    task automatic test_read_hit();
        int   n;
        exp_t e;
        bus.l2_stall = 1'b0;
        bus.l2_block = {16{8'hA5}};
        bus.i_addr   = 32'h40;
        bus.i_req    = 1'b1;
        push_exp(1'b0, {16{8'hA5}});
        @(negedge clk);
        compared++;
        if (bus.l2_read !== 1'b1 || bus.l2_write !== 1'b0 || bus.l2_addr !== 32'h40 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hit_strobe: got rd=%b wr=%b addr=%h busy=%b, expected 1/0/00000040/1",
                     bus.l2_read, bus.l2_write, bus.l2_addr, bus.busy);
        end
        wait_ack(8, n);
        compared++;
        if (n !== 1 || bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hit_latency: got %0d edges i_ack=%b d_ack=%b, expected 2 edges 1/0",
                     n + 1, bus.i_ack, bus.d_ack);
        end
        e = sb_pop();
        compared++;
        if (e.is_d !== 1'b0 || bus.i_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL hit_sb: got i_block=%h, expected %h (side %b)", bus.i_block, e.block, e.is_d);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0 || bus.i_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hit_idle: got busy=%b i_ack=%b, expected 0/0", bus.busy, bus.i_ack);
        end
    endtask

    task automatic test_round_robin();
        int   n;
        exp_t e;
        logic [127:0] blk;
        apply_reset();
        blk = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        bus.l2_block = blk;
        bus.i_addr   = 32'h100;
        bus.d_addr   = 32'h104;
        bus.d_we     = 1'b0;
        bus.i_req    = 1'b1;
        bus.d_req    = 1'b1;
        push_exp(1'b0, blk);
        push_exp(1'b1, blk);
        wait_ack(10, n);
        compared++;
        if (n !== 2 || bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_first_i: got %0d edges i_ack=%b d_ack=%b, expected 2 edges 1/0",
                     n, bus.i_ack, bus.d_ack);
        end
        e = sb_pop();
        compared++;
        if (e.is_d !== 1'b0 || bus.i_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL rr_first_sb: got i_block=%h, expected %h", bus.i_block, e.block);
        end
        bus.i_req = 1'b0;
        wait_ack(10, n);
        compared++;
        if (n !== 3 || bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_second_d: got %0d edges d_ack=%b i_ack=%b, expected 3 edges 1/0",
                     n, bus.d_ack, bus.i_ack);
        end
        e = sb_pop();
        compared++;
        if (e.is_d !== 1'b1 || bus.d_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL rr_second_sb: got d_block=%h, expected %h", bus.d_block, e.block);
        end
        bus.d_req = 1'b0;
        @(negedge clk);

        // A lone I read makes I the last winner, so the next tie must go to D.
        bus.i_addr = 32'h108;
        bus.i_req  = 1'b1;
        push_exp(1'b0, blk);
        wait_ack(10, n);
        e = sb_pop();
        compared++;
        if (n !== 2 || bus.i_ack !== 1'b1 || e.is_d !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_single_i: got %0d edges i_ack=%b, expected 2 edges 1", n, bus.i_ack);
        end
        bus.i_req = 1'b0;
        @(negedge clk);

        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        push_exp(1'b1, blk);
        push_exp(1'b0, blk);
        @(negedge clk);
        compared++;
        if (bus.l2_addr !== 32'h104 || bus.l2_read !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rr_tie_d: got addr=%h rd=%b, expected 00000104/1", bus.l2_addr, bus.l2_read);
        end
        wait_ack(10, n);
        e = sb_pop();
        compared++;
        if (n !== 1 || bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || e.is_d !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rr_tie_d_ack: got %0d edges d_ack=%b i_ack=%b, expected 1 edge 1/0",
                     n, bus.d_ack, bus.i_ack);
        end
        bus.d_req = 1'b0;
        wait_ack(10, n);
        e = sb_pop();
        compared++;
        if (n !== 3 || bus.i_ack !== 1'b1 || e.is_d !== 1'b0 || bus.i_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL rr_tie_i_ack: got %0d edges i_ack=%b i_block=%h, expected 3 edges 1 %h",
                     n, bus.i_ack, bus.i_block, e.block);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int   n;
        exp_t e;
        bus.d_addr  = 32'h13;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_we    = 1'b1;
        bus.d_req   = 1'b1;
        push_exp(1'b1, model_d_block);
        @(negedge clk);
        compared++;
        if (bus.l2_write !== 1'b1 || bus.l2_read !== 1'b0 || bus.l2_addr !== 32'h13 || bus.l2_wdata !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL wr_strobe: got wr=%b rd=%b addr=%h wdata=%h, expected 1/0/00000013/deadbeef",
                     bus.l2_write, bus.l2_read, bus.l2_addr, bus.l2_wdata);
        end
        wait_ack(8, n);
        compared++;
        if (n !== 1 || bus.d_ack !== 1'b1 || bus.l2_write !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wr_ack: got %0d edges d_ack=%b wr=%b, expected 2 edges 1/0",
                     n + 1, bus.d_ack, bus.l2_write);
        end
        e = sb_pop();
        compared++;
        if (e.is_d !== 1'b1 || bus.d_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL wr_sb: got d_block=%h, expected unchanged %h", bus.d_block, e.block);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        int   n;
        exp_t e;
        bus.l2_block = '0;
        bus.l2_stall = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_addr   = 32'h80;
        bus.d_req    = 1'b1;
        push_exp(1'b1, 128'h1234);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            compared++;
            if (bus.l2_read !== 1'b1 || bus.l2_addr !== 32'h80 || bus.d_ack !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL miss_hold_%0d: got rd=%b addr=%h d_ack=%b, expected 1/00000080/0",
                         k, bus.l2_read, bus.l2_addr, bus.d_ack);
            end
            if (k == 5) begin
                bus.i_addr = 32'h200;
                bus.i_req  = 1'b1;
                push_exp(1'b0, 128'h1234);
            end
            if (k == 10) begin
                bus.l2_stall = 1'b0;
                bus.l2_block = 128'h1234;
            end
        end
        wait_ack(4, n);
        compared++;
        if (n !== 1 || bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL miss_latency: got %0d edges d_ack=%b i_ack=%b, expected 11 edges 1/0",
                     n + 10, bus.d_ack, bus.i_ack);
        end
        e = sb_pop();
        compared++;
        if (e.is_d !== 1'b1 || bus.d_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL miss_sb: got d_block=%h, expected %h", bus.d_block, e.block);
        end
        bus.d_req = 1'b0;
        wait_ack(8, n);
        e = sb_pop();
        compared++;
        if (n !== 3 || bus.i_ack !== 1'b1 || e.is_d !== 1'b0 || bus.i_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL miss_pending_i: got %0d edges i_ack=%b i_block=%h, expected 3 edges 1 %h",
                     n, bus.i_ack, bus.i_block, e.block);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int   n;
        exp_t e;
        bus.l2_stall = 1'b1;
        bus.l2_block = 128'hFFFF;
        bus.i_addr   = 32'h300;
        bus.i_req    = 1'b1;
        push_exp(1'b0, model_i_block);
        wait_ack(80, n);
        compared++;
        if (n !== 65 || bus.i_ack !== 1'b1 || bus.err !== 1'b1 || bus.l2_read !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL timeout_abort: got %0d edges i_ack=%b err=%b rd=%b, expected 65 edges 1/1/0",
                     n, bus.i_ack, bus.err, bus.l2_read);
        end
        e = sb_pop();
        compared++;
        if (e.is_d !== 1'b0 || bus.i_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL timeout_sb: got i_block=%h, expected unchanged %h", bus.i_block, e.block);
        end
        bus.i_req    = 1'b0;
        bus.l2_stall = 1'b0;
        @(negedge clk);
        bus.d_addr = 32'h400;
        bus.d_req  = 1'b1;
        push_exp(1'b1, 128'hFFFF);
        wait_ack(8, n);
        e = sb_pop();
        compared++;
        if (n !== 2 || bus.d_ack !== 1'b1 || bus.err !== 1'b1 || bus.d_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL timeout_sticky: got %0d edges d_ack=%b err=%b d_block=%h, expected 2 edges 1/1 %h",
                     n, bus.d_ack, bus.err, bus.d_block, e.block);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   n;
        exp_t e;
        bus.l2_stall = 1'b1;
        bus.i_addr   = 32'h500;
        bus.i_req    = 1'b1;
        repeat (5) @(negedge clk);
        compared++;
        if (bus.l2_read !== 1'b1 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_pre: got rd=%b busy=%b, expected 1/1", bus.l2_read, bus.busy);
        end
        #2 rst = 1'b0;
        sb.delete();
        model_i_block = '0;
        model_d_block = '0;
        #1;
        compared++;
        if (bus.l2_read !== 1'b0 || bus.busy !== 1'b0 || bus.i_ack !== 1'b0 || bus.err !== 1'b0 || bus.l2_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_async: got rd=%b busy=%b i_ack=%b err=%b addr=%h, expected 0/0/0/0/0",
                     bus.l2_read, bus.busy, bus.i_ack, bus.err, bus.l2_addr);
        end
        repeat (2) @(negedge clk);
        compared++;
        if (bus.i_ack !== 1'b0 || bus.l2_read !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_hold: got i_ack=%b rd=%b, expected 0/0", bus.i_ack, bus.l2_read);
        end
        rst          = 1'b1;
        bus.l2_stall = 1'b0;
        bus.l2_block = 128'hBEEF;
        push_exp(1'b0, 128'hBEEF);
        @(negedge clk);
        compared++;
        if (bus.l2_read !== 1'b1 || bus.l2_addr !== 32'h500) begin
            mismatched++;
            $display("[TB] FAIL rstmid_regrant: got rd=%b addr=%h, expected 1/00000500", bus.l2_read, bus.l2_addr);
        end
        wait_ack(8, n);
        e = sb_pop();
        compared++;
        if (n !== 1 || bus.i_ack !== 1'b1 || e.is_d !== 1'b0 || bus.i_block !== e.block) begin
            mismatched++;
            $display("[TB] FAIL rstmid_ack: got %0d edges i_ack=%b i_block=%h, expected 2 edges 1 %h",
                     n + 1, bus.i_ack, bus.i_block, e.block);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_read_hit();
        test_round_robin();
        test_write();
        test_read_miss();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
